// File: rtl/asrv32_lsu.sv
// rtl/asrv32_lsu.sv - load/store unit with req/ack data-bus handshake, fault detection and timeout
//
// Purpose: accepts one load/store request from the execute stage, checks size/alignment,
// issues a single data-bus transaction and returns the extended load result or a fault.
//
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_start                request pulse, only sampled while idle
//   i_is_store, i_funct3   access type and RISC-V size/sign code
//   i_addr, i_rs2_data     byte address and LSB-aligned store data
//   o_bus_*                registered data-bus request (address aligned to the bus width)
//   i_bus_ack/err/rdata    bus response
//   o_busy                 core stall while the bus request is outstanding
//   o_done                 one-cycle completion pulse, qualifies o_fault*
//   o_load_data            extended load result, held until the next successful load
//   o_fault, o_fault_cause 1 = misaligned/unsupported, 2 = bus error, 3 = timeout
//   o_fault_addr           address of the faulting request
module asrv32_lsu #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_is_store,
    input  logic [2:0]            i_funct3,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [DATA_W-1:0]     i_rs2_data,
    output logic                  o_bus_req,
    output logic                  o_bus_we,
    output logic [ADDR_W-1:0]     o_bus_addr,
    output logic [DATA_W-1:0]     o_bus_wdata,
    output logic [DATA_W/8-1:0]   o_bus_wmask,
    input  logic                  i_bus_ack,
    input  logic                  i_bus_err,
    input  logic [DATA_W-1:0]     i_bus_rdata,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_W-1:0]     o_load_data,
    output logic                  o_fault,
    output logic [1:0]            o_fault_cause,
    output logic [ADDR_W-1:0]     o_fault_addr
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_t;

    state_t              state_q, state_d;
    logic                bus_req_q, bus_req_d;
    logic                bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic [STRB_W-1:0]   bus_wmask_q, bus_wmask_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   load_data_q, load_data_d;
    logic                fault_q, fault_d;
    logic [1:0]          fault_cause_q, fault_cause_d;
    logic [ADDR_W-1:0]   fault_addr_q, fault_addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;

    logic [OFF_W-1:0]    in_off, req_off;
    logic                misaligned, unsupported;
    logic [7:0]          size_mask;
    logic [STRB_W-1:0]   in_wmask;
    logic [DATA_W-1:0]   in_wdata;
    logic [DATA_W-1:0]   rd_shift, load_ext;
    logic                sign_bit;
    logic [CNT_W-1:0]    cnt_inc;
    logic                timed_out;
    int                  nbits;

    assign in_off  = i_addr[OFF_W-1:0];
    assign req_off = req_addr_q[OFF_W-1:0];
    assign cnt_inc = cnt_q + CNT_W'(1);
    // cnt_q counts REQ cycles already spent, so the request is dropped after exactly TIMEOUT cycles.
    assign timed_out = (TIMEOUT != 0) && (cnt_inc == TMO_LIM);

    // Request decode, lane placement of store data.
    always_comb begin
        misaligned = 1'b0;
        size_mask  = 8'h01;
        case (i_funct3[1:0])
            2'b01: begin misaligned = i_addr[0];      size_mask = 8'h03; end
            2'b10: begin misaligned = |i_addr[1:0];   size_mask = 8'h0F; end
            2'b11: begin misaligned = |i_addr[2:0];   size_mask = 8'hFF; end
            default: begin misaligned = 1'b0;         size_mask = 8'h01; end
        endcase
        // 64-bit-only codes (LD/SD, LWU) are rejected on a 32-bit bus.
        unsupported = (i_funct3 == 3'b111) || (i_is_store && i_funct3[2])
                   || ((DATA_W == 32) && ((i_funct3 == 3'b011) || (i_funct3 == 3'b110)));
        in_wmask = STRB_W'(size_mask) << in_off;
        in_wdata = i_rs2_data << {in_off, 3'b000};
    end

    // Load lane select and sign/zero extension from the access size.
    always_comb begin
        rd_shift = i_bus_rdata >> {req_off, 3'b000};
        nbits    = 8 << funct3_q[1:0];
        case (funct3_q[1:0])
            2'b00:   sign_bit = rd_shift[7];
            2'b01:   sign_bit = rd_shift[15];
            2'b10:   sign_bit = rd_shift[31];
            default: sign_bit = rd_shift[DATA_W-1];
        endcase
        sign_bit = sign_bit & ~funct3_q[2];
        load_ext = rd_shift;
        for (int i = 0; i < DATA_W; i++) begin
            load_ext[i] = (i < nbits) ? rd_shift[i] : sign_bit;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        bus_wmask_d   = bus_wmask_q;
        busy_d        = busy_q;
        done_d        = done_q;
        load_data_d   = load_data_q;
        fault_d       = fault_q;
        fault_cause_d = fault_cause_q;
        fault_addr_d  = fault_addr_q;
        cnt_d         = cnt_q;
        funct3_d      = funct3_q;
        req_addr_d    = req_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    funct3_d   = i_funct3;
                    req_addr_d = i_addr;
                    if (misaligned || unsupported) begin
                        state_d       = ST_DONE;
                        done_d        = 1'b1;
                        fault_d       = 1'b1;
                        fault_cause_d = 2'd1;
                        fault_addr_d  = i_addr;
                    end else begin
                        state_d     = ST_REQ;
                        bus_req_d   = 1'b1;
                        busy_d      = 1'b1;
                        bus_we_d    = i_is_store;
                        bus_addr_d  = {i_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        bus_wdata_d = in_wdata;
                        bus_wmask_d = i_is_store ? in_wmask : '0;
                        cnt_d       = '0;
                    end
                end
            end
            ST_REQ: begin
                if (i_bus_err || i_bus_ack || timed_out) begin
                    state_d   = ST_DONE;
                    bus_req_d = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    if (i_bus_err) begin
                        fault_d       = 1'b1;
                        fault_cause_d = 2'd2;
                        fault_addr_d  = req_addr_q;
                    end else if (i_bus_ack) begin
                        if (!bus_we_q) load_data_d = load_ext;
                    end else begin
                        fault_d       = 1'b1;
                        fault_cause_d = 2'd3;
                        fault_addr_d  = req_addr_q;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_DONE: begin
                state_d       = ST_IDLE;
                done_d        = 1'b0;
                fault_d       = 1'b0;
                fault_cause_d = 2'd0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ST_IDLE;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_wdata_q   <= '0;
            bus_wmask_q   <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            load_data_q   <= '0;
            fault_q       <= 1'b0;
            fault_cause_q <= 2'd0;
            fault_addr_q  <= '0;
            cnt_q         <= '0;
            funct3_q      <= 3'd0;
            req_addr_q    <= '0;
        end else begin
            state_q       <= state_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            bus_wmask_q   <= bus_wmask_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            load_data_q   <= load_data_d;
            fault_q       <= fault_d;
            fault_cause_q <= fault_cause_d;
            fault_addr_q  <= fault_addr_d;
            cnt_q         <= cnt_d;
            funct3_q      <= funct3_d;
            req_addr_q    <= req_addr_d;
        end
    end

    assign o_bus_req     = bus_req_q;
    assign o_bus_we      = bus_we_q;
    assign o_bus_addr    = bus_addr_q;
    assign o_bus_wdata   = bus_wdata_q;
    assign o_bus_wmask   = bus_wmask_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_load_data   = load_data_q;
    assign o_fault       = fault_q;
    assign o_fault_cause = fault_cause_q;
    assign o_fault_addr  = fault_addr_q;
endmodule

// File: tb/tb_asrv32_lsu.sv
// tb/tb_asrv32_lsu.sv - randomized self-checking bench for asrv32_lsu (32-bit and 64-bit instances)
module tb_asrv32_lsu;
    localparam int TMO0 = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  start = '0, st = '0, ack = '0, err = '0;
    logic [2:0]  f3 [2];
    logic [31:0] addr [2];
    logic [63:0] rs2 [2], rdata [2];
    logic [63:0] exp_ld [2];

    wire  [1:0]  breq, bwe, busy, done, fault;
    wire  [1:0]  cause [2];
    wire  [31:0] baddr [2], faddr [2];
    wire  [31:0] wd0, ld0;
    wire  [3:0]  wm0;
    wire  [63:0] wd1, ld1;
    wire  [7:0]  wm1;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    asrv32_lsu #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TMO0)) u_lsu32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]), .i_is_store(st[0]),
        .i_funct3(f3[0]), .i_addr(addr[0]), .i_rs2_data(rs2[0][31:0]),
        .o_bus_req(breq[0]), .o_bus_we(bwe[0]), .o_bus_addr(baddr[0]),
        .o_bus_wdata(wd0), .o_bus_wmask(wm0), .i_bus_ack(ack[0]), .i_bus_err(err[0]),
        .i_bus_rdata(rdata[0][31:0]), .o_busy(busy[0]), .o_done(done[0]),
        .o_load_data(ld0), .o_fault(fault[0]), .o_fault_cause(cause[0]),
        .o_fault_addr(faddr[0])
    );

    asrv32_lsu #(.DATA_W(64), .ADDR_W(32)) u_lsu64 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]), .i_is_store(st[1]),
        .i_funct3(f3[1]), .i_addr(addr[1]), .i_rs2_data(rs2[1]),
        .o_bus_req(breq[1]), .o_bus_we(bwe[1]), .o_bus_addr(baddr[1]),
        .o_bus_wdata(wd1), .o_bus_wmask(wm1), .i_bus_ack(ack[1]), .i_bus_err(err[1]),
        .i_bus_rdata(rdata[1]), .o_busy(busy[1]), .o_done(done[1]),
        .o_load_data(ld1), .o_fault(fault[1]), .o_fault_cause(cause[1]),
        .o_fault_addr(faddr[1])
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: what a memory access of this shape must look like on a bus of dw bytes.
    function automatic void model(input int dw, input bit s, input bit [2:0] fn, input bit [31:0] a,
                                  input bit [63:0] wv, input bit [63:0] rv, output bit bad,
                                  output bit [31:0] ba, output bit [7:0] wm, output bit [63:0] wdv,
                                  output bit [63:0] ldv);
        int nb = 1 << fn[1:0];
        int off = int'(a % dw);
        bit [63:0] dmask = (dw == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
        bit [63:0] vmask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (nb * 8)) - 64'd1);
        bit [63:0] v;
        bad = (fn == 3'd7) || (s && fn[2]) || (dw == 4 && (fn == 3'd3 || fn == 3'd6)) || (a % nb != 0);
        ba  = a - off;
        wm  = s ? 8'(((1 << nb) - 1) << off) : 8'h00;
        wdv = (wv << (off * 8)) & dmask;
        v   = (rv >> (off * 8)) & vmask;
        if (!fn[2] && v[nb * 8 - 1]) v = v | ~vmask;
        ldv = v & dmask;
    endfunction

    task automatic scramble(input int u);
        st[u]   = 1'($urandom);
        f3[u]   = 3'($urandom);
        addr[u] = $urandom;
        rs2[u]  = {$urandom, $urandom};
    endtask

    // mode: 0 ack, 1 error, 2 error with simultaneous ack, 3 no response (timeout)
    task automatic run_txn(input int u, input bit s, input bit [2:0] fn, input bit [31:0] a,
                           input bit [63:0] wv, input bit [63:0] rv, input int w, input int mode);
        bit bad;
        bit [31:0] ba;
        bit [7:0] wm;
        bit [63:0] wdv, ldv;
        int n;
        logic [63:0] got_wd, got_ld;
        logic [7:0] got_wm;
        model(u ? 8 : 4, s, fn, a, wv, rv, bad, ba, wm, wdv, ldv);
        // bus responses while idle must be ignored
        ack[u] = 1'($urandom); err[u] = 1'($urandom); rdata[u] = {$urandom, $urandom};
        @(posedge clk); @(negedge clk);
        check_eq("idle_resp_done", done[u], 0);
        ack[u] = 0; err[u] = 0;
        start[u] = 1; st[u] = s; f3[u] = fn; addr[u] = a; rs2[u] = wv;
        @(posedge clk); @(negedge clk);
        start[u] = 0;
        scramble(u);
        got_ld = u ? ld1 : {32'b0, ld0};
        if (bad) begin
            check_eq("bad_done", done[u], 1);
            check_eq("bad_req", breq[u], 0);
            check_eq("bad_busy", busy[u], 0);
            check_eq("bad_fault", fault[u], 1);
            check_eq("bad_cause", cause[u], 1);
            check_eq("bad_faddr", faddr[u], a);
            check_eq("bad_ld_hold", got_ld, exp_ld[u]);
        end else begin
            n = (mode == 3) ? TMO0 : w + 1;
            for (int i = 0; i < n; i++) begin
                got_wd = u ? wd1 : {32'b0, wd0};
                got_wm = u ? wm1 : {4'b0, wm0};
                check_eq("req_high", breq[u], 1);
                check_eq("req_busy", busy[u], 1);
                check_eq("req_done", done[u], 0);
                check_eq("req_addr", baddr[u], ba);
                check_eq("req_we", bwe[u], s);
                check_eq("req_wmask", got_wm, wm);
                if (s) check_eq("req_wdata", got_wd, wdv);
                if (i == n - 1) begin
                    start[u] = 0;
                    if (mode != 3) begin
                        ack[u] = (mode != 1); err[u] = (mode != 0); rdata[u] = rv;
                    end
                end else begin
                    start[u] = 1'($urandom);
                end
                @(posedge clk); @(negedge clk);
                scramble(u);
            end
            start[u] = 0; ack[u] = 0; err[u] = 0; rdata[u] = {$urandom, $urandom};
            check_eq("end_done", done[u], 1);
            check_eq("end_req", breq[u], 0);
            check_eq("end_busy", busy[u], 0);
            check_eq("end_fault", fault[u], mode != 0);
            if (mode != 0) begin
                check_eq("end_cause", cause[u], (mode == 3) ? 3 : 2);
                check_eq("end_faddr", faddr[u], a);
            end else if (!s) begin
                exp_ld[u] = ldv;
            end
            got_ld = u ? ld1 : {32'b0, ld0};
            check_eq("end_ld", got_ld, exp_ld[u]);
        end
        @(posedge clk); @(negedge clk);
        got_ld = u ? ld1 : {32'b0, ld0};
        check_eq("single_done", done[u], 0);
        check_eq("ld_held", got_ld, exp_ld[u]);
    endtask

    initial begin
        int u, mode, nb;
        bit s;
        bit [2:0] fn;
        bit [31:0] a;
        for (int i = 0; i < 2; i++) begin
            f3[i] = '0; addr[i] = '0; rs2[i] = '0; rdata[i] = '0; exp_ld[i] = '0;
        end
        #2 rst_n = 0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check_eq("rst_req", breq[i], 0);
            check_eq("rst_busy", busy[i], 0);
            check_eq("rst_done", done[i], 0);
            check_eq("rst_fault", fault[i], 0);
            check_eq("rst_cause", cause[i], 0);
            check_eq("rst_baddr", baddr[i], 0);
        end
        check_eq("rst_ld32", ld0, 0);
        check_eq("rst_ld64", ld1, 0);
        check_eq("rst_wm64", wm1, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        run_txn(0, 1, 3'b000, 32'h1003, 64'hA5, 0, 0, 0);
        run_txn(0, 0, 3'b000, 32'h2001, 0, 64'h0000_F200, 3, 0);
        run_txn(0, 0, 3'b100, 32'h2001, 0, 64'h0000_F200, 3, 0);
        run_txn(0, 0, 3'b010, 32'h3002, 0, 0, 0, 0);
        run_txn(0, 1, 3'b001, 32'h3002, 64'h1234, 0, 0, 0);
        run_txn(0, 0, 3'b010, 32'h5000, 0, 64'hDEAD_BEEF, 1, 2);
        run_txn(0, 0, 3'b010, 32'h5004, 0, 0, 0, 3);
        run_txn(0, 0, 3'b001, 32'h5006, 0, 64'h8001_0000, 3, 0);
        run_txn(1, 0, 3'b110, 32'h4004, 0, 64'h8000_0001_0000_0000, 2, 0);
        run_txn(1, 1, 3'b011, 32'h4000, 64'h0123_4567_89AB_CDEF, 0, 0, 0);
        run_txn(1, 0, 3'b011, 32'h4004, 0, 0, 0, 0);
        run_txn(1, 0, 3'b010, 32'h4004, 0, 64'h8000_0001_0000_0000, 0, 0);
        run_txn(0, 1, 3'b101, 32'h6000, 0, 0, 0, 0);

        // reset while a request is outstanding
        @(negedge clk);
        start[0] = 1; st[0] = 0; f3[0] = 3'b010; addr[0] = 32'h100;
        @(posedge clk); @(negedge clk);
        start[0] = 0;
        check_eq("pre_rst_req", breq[0], 1);
        #2 rst_n = 0;
        #1;
        check_eq("async_rst_req", breq[0], 0);
        check_eq("async_rst_busy", busy[0], 0);
        check_eq("async_rst_ld", ld0, 0);
        exp_ld[0] = 0; exp_ld[1] = 0;
        @(negedge clk);
        rst_n = 1; ack[0] = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("post_rst_done", done[0], 0);
            check_eq("post_rst_req", breq[0], 0);
        end
        ack[0] = 0;

        for (int k = 0; k < 300; k++) begin
            u  = int'($urandom_range(0, 1));
            s  = 1'($urandom);
            fn = 3'($urandom);
            nb = 1 << fn[1:0];
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(nb) - 32'd1);
            mode = int'($urandom_range(0, 9));
            mode = (mode < 7) ? 0 : (mode == 7) ? 1 : (mode == 8) ? 2 : (u == 0) ? 3 : 0;
            run_txn(u, s, fn, a, {$urandom, $urandom}, u ? {$urandom, $urandom} : {32'b0, $urandom},
                    int'(u ? $urandom_range(0, 5) : $urandom_range(0, 3)), mode);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
